// File: rtl/ring_phase_decoder_if.sv
// ring_phase_decoder_if: ring sample inputs and decoded phase outputs of the ring phase decoder
interface ring_phase_decoder_if #(
  parameter int N = 4,
  parameter int IDXW = 2,
  parameter int REVW = 8
);
  logic en;
  logic [N-1:0] ring;
  logic err_clr;
  logic [IDXW-1:0] idx;
  logic valid;
  logic rev_tick;
  logic [REVW-1:0] rev_count;
  logic err;
  logic [1:0] state;
  modport master (
    output en, ring, err_clr,
    input idx, valid, rev_tick, rev_count, err, state
  );
  modport slave (
    input en, ring, err_clr,
    output idx, valid, rev_tick, rev_count, err, state
  );
endinterface

// File: rtl/ring_phase_decoder.sv
// ring_phase_decoder: turns a one-hot ring counter into a phase index, revolution count and sticky step-fault flag
module ring_phase_decoder #(
  parameter int N = 4,
  parameter int IDXW = 2,
  parameter int REVW = 8
) (
  input logic clk,
  input logic reset_n,
  ring_phase_decoder_if.slave bus
);
  typedef enum logic [1:0] {SYNC = 2'd0, LOCK = 2'd1, FAULT = 2'd2} state_t;
  state_t st, st_n;
  logic [N-1:0] last, expected;
  logic last_en, one_hot, wrap;
  logic [IDXW-1:0] idx, idx_n, pos;
  logic valid, tick, tick_n, err, err_n;
  logic [REVW-1:0] cnt, cnt_n;
  // binary position of the hot bit in the current sample
  always_comb begin
    pos = '0;
    for (int i = 0; i < N; i++) if (bus.ring[i]) pos = IDXW'(i);
  end
  // where a healthy counter must be now, given what it showed and whether it was enabled
  always_comb begin
    expected = !last_en ? last : (last == '0 ? N'(1) : {last[N-2:0], last[N-1]});
    one_hot = (bus.ring != '0) && ((bus.ring & (bus.ring - 1'b1)) == '0);
    wrap = last_en & last[N-1] & bus.ring[0];
  end
  // lock/fault decisions and the next values of every registered output
  always_comb begin
    st_n = st;
    idx_n = idx;
    tick_n = 1'b0;
    cnt_n = cnt;
    err_n = err;
    case (st)
      SYNC:
        if (one_hot) begin
          st_n = LOCK;
          idx_n = pos;
        end else if (bus.ring != '0) begin
          st_n = FAULT;
          err_n = 1'b1;
        end
      LOCK:
        if (bus.ring == expected) begin
          idx_n = pos;
          tick_n = wrap;
          cnt_n = cnt + REVW'(wrap);
        end else begin
          st_n = FAULT;
          err_n = 1'b1;
        end
      FAULT:
        if (bus.err_clr) begin
          st_n = SYNC;
          err_n = 1'b0;
        end
      default: st_n = SYNC;
    endcase
  end
  // state, outputs and the previous sample, all cleared asynchronously
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st <= SYNC;
      idx <= '0;
      valid <= 1'b0;
      tick <= 1'b0;
      cnt <= '0;
      err <= 1'b0;
      last <= '0;
      last_en <= 1'b0;
    end else begin
      st <= st_n;
      idx <= idx_n;
      valid <= st_n == LOCK;
      tick <= tick_n;
      cnt <= cnt_n;
      err <= err_n;
      last <= bus.ring;
      last_en <= bus.en;
    end
  end
  assign bus.idx = idx;
  assign bus.valid = valid;
  assign bus.rev_tick = tick;
  assign bus.rev_count = cnt;
  assign bus.err = err;
  assign bus.state = st;
endmodule

// File: tb/tb_ring_phase_decoder.sv
// tb_ring_phase_decoder: scoreboard bench comparing the decoder against a behavioural ring-counter observer
module tb_ring_phase_decoder;
  localparam int N = 4;
  localparam int IDXW = 2;
  localparam int REVW = 2;
  typedef struct {
    int idx;
    int valid;
    int tick;
    int cnt;
    int err;
    int st;
  } exp_t;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int m_state, m_idx, m_cnt, m_err, m_tick, m_last, m_last_en;
  ring_phase_decoder_if #(.N(N), .IDXW(IDXW), .REVW(REVW)) bus ();
  ring_phase_decoder #(.N(N), .IDXW(IDXW), .REVW(REVW)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );
  // free-running clock
  always #5 clk = ~clk;
  function automatic int rot(int x);
    return x == 0 ? 1 : (((x << 1) & ((1 << N) - 1)) | (x >> (N - 1)));
  endfunction
  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  task automatic check_outputs(exp_t e);
    check("idx", int'(bus.idx), e.idx);
    check("valid", int'(bus.valid), e.valid);
    check("rev_tick", int'(bus.rev_tick), e.tick);
    check("rev_count", int'(bus.rev_count), e.cnt);
    check("err", int'(bus.err), e.err);
    check("state", int'(bus.state), e.st);
  endtask
  task automatic model_reset();
    m_state = 0;
    m_idx = 0;
    m_cnt = 0;
    m_err = 0;
    m_tick = 0;
    m_last = 0;
    m_last_en = 0;
  endtask
  task automatic model_step(int e, int r, int clr);
    int ex;
    m_tick = 0;
    ex = m_last_en != 0 ? rot(m_last) : m_last;
    case (m_state)
      0:
        if ($countones(r) == 1) begin
          m_state = 1;
          m_idx = $clog2(r);
        end else if (r != 0) begin
          m_state = 2;
          m_err = 1;
        end
      1:
        if (r == ex) begin
          m_idx = $clog2(r);
          if (m_last_en != 0 && m_last == (1 << (N - 1)) && r == 1) begin
            m_tick = 1;
            m_cnt = (m_cnt + 1) % (1 << REVW);
          end
        end else begin
          m_state = 2;
          m_err = 1;
        end
      default:
        if (clr != 0) begin
          m_state = 0;
          m_err = 0;
        end
    endcase
    m_last = r;
    m_last_en = e;
  endtask
  task automatic step(int e, int r, int clr);
    exp_t x;
    @(negedge clk);
    bus.en = e != 0;
    bus.ring = N'(r);
    bus.err_clr = clr != 0;
    model_step(e, r, clr);
    x.idx = m_idx;
    x.valid = int'(m_state == 1);
    x.tick = m_tick;
    x.cnt = m_cnt;
    x.err = m_err;
    x.st = m_state;
    sb.push_back(x);
  endtask
  task automatic do_reset();
    exp_t z;
    z = '{0, 0, 0, 0, 0, 0};
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    bus.en = 1'b0;
    bus.ring = '0;
    bus.err_clr = 1'b0;
    #1;
    model_reset();
    check_outputs(z);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask
  // monitor: every post-edge output set is checked against the oldest queued expectation
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check_outputs(e);
      end
    end
  end
  // stimulus: directed scenarios, then a randomized counter with injected faults
  initial begin
    int fr[6] = '{0, 1, 2, 4, 8, 1};
    int rv[4] = '{1, 2, 4, 8};
    int gen, e, clr, r;
    bus.en = 1'b0;
    bus.ring = '0;
    bus.err_clr = 1'b0;
    model_reset();
    do_reset();
    foreach (fr[i]) step(1, fr[i], 0);
    step(1, 2, 0);
    step(0, 4, 0);
    repeat (5) step(0, 4, 0);
    step(1, 4, 0);
    step(1, 8, 0);
    step(1, 1, 0);
    step(1, 4, 0);
    step(0, 0, 1);
    step(1, 8, 0);
    step(1, 1, 0);
    step(1, 2, 0);
    step(1, 2, 0);
    step(0, 0, 1);
    step(0, 6, 1);
    step(0, 0, 1);
    repeat (5) foreach (rv[i]) step(1, rv[i], 0);
    step(1, 1, 0);
    step(1, 2, 0);
    do_reset();
    step(1, 0, 0);
    step(1, 1, 0);
    step(1, 2, 0);
    step(1, 4, 1);
    step(1, 4, 1);
    gen = 0;
    repeat (3000) begin
      e = int'($urandom_range(0, 3) != 0);
      clr = int'($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 29) == 0) begin
        r = int'($urandom_range(0, (1 << N) - 1));
        gen = 1 << $urandom_range(0, N - 1);
      end else begin
        r = gen;
        if (e != 0) gen = rot(gen);
      end
      step(e, r, clr);
    end
    repeat (3) @(negedge clk);
    check("drain", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ring_phase_decoder.md
Name: ring_phase_decoder

Overview:
- Consumer side of the one-hot ring counter. Samples the counter's N-bit one-hot phase vector and the same enable that drives the counter.
- Produces a registered binary phase index, a revolution tick and a revolution count.
- Checks every observed step against legal ring-counter behaviour and latches a sticky error on any violation.
- Sits next to the ring counter in sequencer/scan paths, which consume phase numbers rather than one-hot strobes.

Parameters:
- N, 4: ring width (number of phases), N >= 2.
- IDXW, 2: width of idx; must satisfy 2^IDXW >= N.
- REVW, 8: width of the revolution counter.

Ports:
- clk  input  1  rising-edge clock, shared with the ring counter.
- reset_n  input  1  asynchronous active-low reset.
- en  input  1  same enable that drives the ring counter.
- ring  input  N  ring counter output q.
- err_clr  input  1  clears a sticky fault; acted on only in FAULT.
- idx  output  IDXW  binary position of the hot bit in the last accepted sample.
- valid  output  1  high while the state is LOCK.
- rev_tick  output  1  one-cycle pulse on wrap from phase N-1 to phase 0.
- rev_count  output  REVW  count of completed revolutions; wraps modulo 2^REVW.
- err  output  1  sticky fault flag.
- state  output  2  SYNC=0, LOCK=1, FAULT=2.

Behaviour:
- Reset is asynchronous on reset_n low. All of the following apply immediately, without a clock edge:
  - idx=0, valid=0, rev_tick=0, rev_count=0, err=0, state=SYNC.
  - Internal last=0, last_en=0.
- Sampling:
  - On every rising edge, in every state, ring is sampled as new.
  - After the edge's decisions are made, last<=new and last_en<=en.
- Expected value of new:
  - If last_en=1: expected = last rotated left by one (bit N-1 wraps to bit 0). When last=0, expected is 0...01.
  - If last_en=0: expected = last.
- Legality: new is legal one-hot if exactly one bit is set. new=0 is legal only in SYNC (counter start-up state).
- SYNC:
  - new=0: stay in SYNC.
  - new legal one-hot: go to LOCK, set valid=1, set idx=encode(new). No rev_tick.
  - new multi-hot: go to FAULT, set err=1.
- LOCK:
  - new equals expected: idx<=encode(new).
  - If in addition last[N-1]=1 and new[0]=1 with last_en=1: rev_tick=1 for that cycle and rev_count<=rev_count+1.
  - new differs from expected (skip, stall while enabled, spurious step while disabled, zero, multi-hot): go to FAULT, set err=1, valid=0. idx holds its last good value. No tick, no count.
- FAULT:
  - valid=0; idx and rev_count hold.
  - err_clr=1 at an edge: err<=0, go to SYNC. Relock then follows the normal SYNC rules from the next sample.
- err_clr outside FAULT has no effect. A fault detected in LOCK on the same edge as err_clr=1 still sets err and enters FAULT.
- rev_tick is high for exactly one cycle per wrap and is 0 in all other cycles.
- Latency: ring changes at edge k, is sampled at edge k+1, and idx, rev_tick and err update at edge k+1. Outputs therefore lag ring by one cycle.
- rev_count wraps from 2^REVW-1 to 0 silently; no error is raised.
- encode() returns the bit position of the single set bit, zero-extended to IDXW.
- All outputs are registered, with no combinational paths from inputs to outputs.

Test Plan:
- Free run, N=4: reset, then release with en=1 and counter starting at 0000. Ring samples 0000, 0001, 0010, 0100, 1000, 0001. Required: valid rises on the 0001 sample; idx goes 0,1,2,3,0; rev_tick pulses once on the 3->0 step; rev_count=1; err=0.
- Hold: in LOCK at idx=2 (ring=0100), drop en for 5 cycles with ring held. Required: idx stays 2, valid stays 1, err=0, rev_tick=0. Resume with en=1: idx becomes 3.
- Skip fault: in LOCK, force ring 0001 -> 0100 with en=1. Required: err=1, valid=0, state=FAULT, idx=0 held. Pulse err_clr: state=SYNC, err=0. Next legal sample 1000 relocks with idx=3.
- Stall fault: en=1 but ring held at 0010 for two samples. Required: FAULT. A multi-hot 0110 seen in SYNC also gives FAULT with err=1.
- Wrap: with REVW=2, run 5 full revolutions. Required: rev_count goes 1,2,3,0,1 with exactly 5 rev_tick pulses.
- Async reset: assert reset_n low mid-LOCK between clock edges. Required: all outputs go to 0 and state=SYNC before the next edge; after release, the block relocks normally.
